ntt_pingpong_controller: RTL
============================

NTT_PINGPONG_CONTROLLER -- requirements
Module: ntt_pingpong_controller

Interface
REQ-001 SHALL have parameter N, default 256, meaning transform size (power of 2, >=4); LOG2N = log2(N).
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(N), meaning BRAM and ROM address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 12, meaning coefficient width.
REQ-004 SHALL have parameter LATENCY, default 3, meaning butterfly valid_in->valid_out delay in cycles (>=1).
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-007 SHALL have port enable, input, 1, meaning start pulse; mode, input, 1, meaning 0=NTT, 1=INTT, sampled with enable.
REQ-008 SHALL have ports busy, done, result_bank, outputs, 1 each, meaning operation active, 1-cycle completion pulse, bank holding the result.
REQ-009 SHALL have ports bramX_addr_a/b, output, ADDR_WIDTH; bramX_we_a/b, output, 1; bramX_din_a/b, output, DATA_WIDTH; bramX_dout_a/b, input, DATA_WIDTH (X=0,1), meaning dual-port ping-pong banks with 1-cycle read.
REQ-010 SHALL have ports rom_addr, output, ADDR_WIDTH; rom_dout, input, DATA_WIDTH, meaning twiddle ROM with 1-cycle read.
REQ-011 SHALL have ports butterfly_in1/in2/twiddle, output, DATA_WIDTH; butterfly_inverse, valid_in, outputs, 1; valid_out, input, 1; butterfly_u/v, inputs, DATA_WIDTH.

Function
REQ-012 SHALL implement states IDLE, ISSUE, DRAIN, COPY, FINISH; IDLE->ISSUE on enable; ISSUE->DRAIN after N/2 issues; DRAIN->ISSUE (next stage) the cycle after the stage's last write; after stage LOG2N-1, DRAIN->COPY or FINISH; FINISH->IDLE after 1 cycle with done=1.
REQ-013 SHALL use constant geometry: stage s (0..LOG2N-1), butterfly k (0..N/2-1): read source bank s%2 at addr_a=k, addr_b=k+N/2; write destination bank at addr_a=2k (u), addr_b=2k+1 (v).
REQ-014 SHALL drive rom_addr = tw_idx + (mode ? N/2 : 0), tw_idx = k with low (LOG2N-1-s) bits cleared, in the same cycle as the BRAM read.
REQ-015 SHALL issue one butterfly per cycle; assert valid_in the cycle after issue with butterfly_in1/in2 = source dout_a/dout_b, butterfly_twiddle = rom_dout, butterfly_inverse = latched mode.
REQ-016 SHALL assert destination we_a and we_b exactly in cycles where valid_out=1, din_a=butterfly_u, din_b=butterfly_v, addresses from an internal write counter; non-destination bank we=0.
REQ-017 SHALL give stage length N/2+LATENCY+1 cycles; no stage overlap (read-after-write safe).
REQ-018 SHALL ignore enable while busy; busy=1 from cycle after accepted enable through the done cycle.
REQ-019 SHALL set result_bank = LOG2N%2 at done (0 if copy-back performed); hold until next start.
REQ-020 SHALL ignore valid_out outside ISSUE/DRAIN.

Reset
REQ-021 SHALL on rst force IDLE, busy=done=valid_in=result_bank=0, all we=0, addresses and rom_addr=0, butterfly_inverse=0, from the next edge.
REQ-022 SHALL on rst mid-operation abort immediately; bank contents then undefined; no done pulse issued.

Configuration
REQ-023 SHALL with macro NTT_COPYBACK_EN defined and LOG2N odd, after final stage run COPY: N/2 cycles reading bank1 (2k,2k+1), writing bank0 same addresses one cycle later, then FINISH; adds N/2+1 cycles.
REQ-024 SHALL without NTT_COPYBACK_EN omit COPY state and logic; result stays in bank LOG2N%2.

Verification
REQ-025 SHALL test N=4, LATENCY=3, enable at cycle 0 -> reads (0,2),(1,3) cycles 1-2; bank1 writes (0,1),(2,3) cycles 5-6; done at cycle 13; result_bank=0.
REQ-026 SHALL test N=4 rom_addr: mode=0 -> 0,0 then 0,1; mode=1 -> 2,2 then 2,3; butterfly_inverse=mode.
REQ-027 SHALL test N=8, LATENCY=3, no NTT_COPYBACK_EN -> done at cycle 25, result_bank=1; with it -> done at cycle 30, result_bank=0, bank0 equals pre-copy bank1.
REQ-028 SHALL test enable pulsed at cycle 5 during busy -> ignored, done still at cycle 13 (N=4).
REQ-029 SHALL test rst at cycle 4 mid-stage -> next cycle busy=0, all we=0, no done; fresh enable then completes normally.

Source files
------------

// File: rtl/ntt_pingpong_controller.sv
// ntt_pingpong_controller: sequences a constant-geometry NTT/INTT over two ping-pong BRAM banks.
// Latency: LOG2N*(N/2+LATENCY+1)+1 cycles from accepted enable to done (+N/2+1 with copy-back).
// Backpressure: none; one butterfly per cycle, enable ignored while busy, valid_out trusted.
//
// Ports:
//   clk, rst (sync, active-high), enable (start pulse), mode (0=NTT, 1=INTT, sampled with enable)
//   busy, done (1-cycle pulse), result_bank (bank holding the final coefficients)
//   bram{0,1}_{addr,we,din}_{a,b} out, bram{0,1}_dout_{a,b} in (1-cycle read latency)
//   rom_addr out, rom_dout in (twiddle ROM, 1-cycle read latency)
//   butterfly_in1/in2/twiddle/inverse, valid_in out; valid_out, butterfly_u/v in
// Build option: define NTT_COPYBACK_EN to copy an odd-stage-count result back into bank 0.
module ntt_pingpong_controller #(
  parameter int N          = 256,
  parameter int ADDR_WIDTH = $clog2(N),
  parameter int DATA_WIDTH = 12,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  mode,
  output logic                  busy,
  output logic                  done,
  output logic                  result_bank,
  output logic [ADDR_WIDTH-1:0] bram0_addr_a,
  output logic [ADDR_WIDTH-1:0] bram0_addr_b,
  output logic                  bram0_we_a,
  output logic                  bram0_we_b,
  output logic [DATA_WIDTH-1:0] bram0_din_a,
  output logic [DATA_WIDTH-1:0] bram0_din_b,
  input  logic [DATA_WIDTH-1:0] bram0_dout_a,
  input  logic [DATA_WIDTH-1:0] bram0_dout_b,
  output logic [ADDR_WIDTH-1:0] bram1_addr_a,
  output logic [ADDR_WIDTH-1:0] bram1_addr_b,
  output logic                  bram1_we_a,
  output logic                  bram1_we_b,
  output logic [DATA_WIDTH-1:0] bram1_din_a,
  output logic [DATA_WIDTH-1:0] bram1_din_b,
  input  logic [DATA_WIDTH-1:0] bram1_dout_a,
  input  logic [DATA_WIDTH-1:0] bram1_dout_b,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  output logic [DATA_WIDTH-1:0] butterfly_in1,
  output logic [DATA_WIDTH-1:0] butterfly_in2,
  output logic [DATA_WIDTH-1:0] butterfly_twiddle,
  output logic                  butterfly_inverse,
  output logic                  valid_in,
  input  logic                  valid_out,
  input  logic [DATA_WIDTH-1:0] butterfly_u,
  input  logic [DATA_WIDTH-1:0] butterfly_v
);

  localparam int LOG2N     = $clog2(N);
  localparam int HALF      = N / 2;
  localparam int STAGE_LEN = HALF + LATENCY + 1;
  localparam int CW        = $clog2(STAGE_LEN + 1);
  localparam int SW        = $clog2(LOG2N) + 1;

  localparam logic [CW-1:0]         LAST_ISSUE = CW'(HALF - 1);
  localparam logic [CW-1:0]         LAST_DRAIN = CW'(STAGE_LEN - 1);
  localparam logic [SW-1:0]         LAST_STAGE = SW'(LOG2N - 1);
  localparam logic [ADDR_WIDTH-1:0] HALF_A     = ADDR_WIDTH'(HALF);
  localparam logic [ADDR_WIDTH-1:0] ONE_A      = ADDR_WIDTH'(1);
  localparam logic                  NAT_BANK   = 1'(LOG2N % 2);

`ifdef NTT_COPYBACK_EN
  localparam logic [CW-1:0] LAST_COPY = CW'(HALF);
  localparam bit            DO_COPY   = (LOG2N % 2) == 1;
  localparam logic          FINAL_BANK = DO_COPY ? 1'b0 : NAT_BANK;
`else
  localparam logic          FINAL_BANK = NAT_BANK;
`endif

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
`ifdef NTT_COPYBACK_EN
    COPY,
`endif
    FINISH
  } state_t;

  state_t                state, state_n;
  logic [SW-1:0]         stage;
  logic [CW-1:0]         cnt;      // cycle within stage (k while issuing) or copy step
  logic [ADDR_WIDTH-1:0] wr_cnt;   // butterfly results written so far this stage
  logic                  mode_r;

  logic                  issuing, in_stage, wr_en, src;
  logic [ADDR_WIDTH-1:0] rd_k, tw_mask, wr_addr_a, wr_addr_b;
  logic [SW-1:0]         shamt;

  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);
  assign issuing   = (state == ISSUE);
  assign in_stage  = (state == ISSUE) || (state == DRAIN);
  assign wr_en     = valid_out && in_stage;
  assign src       = stage[0];
  assign rd_k      = ADDR_WIDTH'(cnt);
  assign wr_addr_a = {wr_cnt[ADDR_WIDTH-2:0], 1'b0};
  assign wr_addr_b = {wr_cnt[ADDR_WIDTH-2:0], 1'b1};

  // Twiddle index keeps only the top (s+1) bits of k: clear the low LOG2N-1-s bits.
  assign shamt    = LAST_STAGE - stage;
  assign tw_mask  = {ADDR_WIDTH{1'b1}} << shamt;
  assign rom_addr = issuing ? ((rd_k & tw_mask) + (mode_r ? HALF_A : '0)) : '0;

  // Operands arrive one cycle after issue; the stage cannot have advanced yet because
  // the last issue is always followed by at least LATENCY+1 drain cycles.
  assign butterfly_in1     = valid_in ? (src ? bram1_dout_a : bram0_dout_a) : '0;
  assign butterfly_in2     = valid_in ? (src ? bram1_dout_b : bram0_dout_b) : '0;
  assign butterfly_twiddle = valid_in ? rom_dout : '0;
  assign butterfly_inverse = mode_r;

`ifdef NTT_COPYBACK_EN
  logic                  copy_rd, copy_wr;
  logic [ADDR_WIDTH-1:0] cp_wk;
  assign copy_rd = (state == COPY) && (cnt != LAST_COPY);
  assign copy_wr = (state == COPY) && (cnt != '0);
  assign cp_wk   = rd_k - ONE_A;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (enable) state_n = ISSUE;
      ISSUE: if (cnt == LAST_ISSUE) state_n = DRAIN;
      DRAIN: begin
        if (cnt == LAST_DRAIN) begin
          if (stage == LAST_STAGE) begin
`ifdef NTT_COPYBACK_EN
            state_n = DO_COPY ? COPY : FINISH;
`else
            state_n = FINISH;
`endif
          end else begin
            state_n = ISSUE;
          end
        end
      end
`ifdef NTT_COPYBACK_EN
      COPY:  if (cnt == LAST_COPY) state_n = FINISH;
`endif
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bank port steering: destination bank takes writes, source bank takes reads.
  always_comb begin
    bram0_addr_a = '0; bram0_addr_b = '0; bram0_we_a = 1'b0; bram0_we_b = 1'b0;
    bram0_din_a  = '0; bram0_din_b  = '0;
    bram1_addr_a = '0; bram1_addr_b = '0; bram1_we_a = 1'b0; bram1_we_b = 1'b0;
    bram1_din_a  = '0; bram1_din_b  = '0;
    if (wr_en) begin
      if (src) begin
        bram0_addr_a = wr_addr_a; bram0_addr_b = wr_addr_b;
        bram0_we_a   = 1'b1;      bram0_we_b   = 1'b1;
        bram0_din_a  = butterfly_u; bram0_din_b = butterfly_v;
      end else begin
        bram1_addr_a = wr_addr_a; bram1_addr_b = wr_addr_b;
        bram1_we_a   = 1'b1;      bram1_we_b   = 1'b1;
        bram1_din_a  = butterfly_u; bram1_din_b = butterfly_v;
      end
    end
    if (issuing) begin
      if (src) begin
        bram1_addr_a = rd_k; bram1_addr_b = rd_k + HALF_A;
      end else begin
        bram0_addr_a = rd_k; bram0_addr_b = rd_k + HALF_A;
      end
    end
`ifdef NTT_COPYBACK_EN
    if (copy_rd) begin
      bram1_addr_a = {rd_k[ADDR_WIDTH-2:0], 1'b0};
      bram1_addr_b = {rd_k[ADDR_WIDTH-2:0], 1'b1};
    end
    if (copy_wr) begin
      bram0_addr_a = {cp_wk[ADDR_WIDTH-2:0], 1'b0};
      bram0_addr_b = {cp_wk[ADDR_WIDTH-2:0], 1'b1};
      bram0_we_a   = 1'b1;
      bram0_we_b   = 1'b1;
      bram0_din_a  = bram1_dout_a;
      bram0_din_b  = bram1_dout_b;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      stage       <= '0;
      cnt         <= '0;
      wr_cnt      <= '0;
      mode_r      <= 1'b0;
      valid_in    <= 1'b0;
      result_bank <= 1'b0;
    end else begin
      state    <= state_n;
      valid_in <= issuing;
      if (state == IDLE && enable) mode_r <= mode;
      // Counter restarts on every state change except ISSUE->DRAIN, which continues the stage.
      if ((state_n != state) && (state_n != DRAIN)) cnt <= '0;
      else if (busy) cnt <= cnt + CW'(1);
      if (state == IDLE && enable) stage <= '0;
      else if (state == DRAIN && state_n == ISSUE) stage <= stage + SW'(1);
      if (state_n == ISSUE && state != ISSUE) wr_cnt <= '0;
      else if (wr_en) wr_cnt <= wr_cnt + ONE_A;
      if (state_n == FINISH && state != FINISH) result_bank <= FINAL_BANK;
    end
  end

endmodule
